carregador_de_programa: RTL and testbench
=========================================

Name: carregador_de_programa

Overview:
Boot-time program loader for the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles 32-bit instruction words big-endian and writes them at consecutive addresses from 0 through the memory's write port. It holds the CPU in stall until the load completes, then releases it with PC at 0. It replaces the hard-coded first-clock initialisation of the instruction memory.

Parameters:
MEM_SIZE, 150, number of instruction words in the instruction memory.
ADDR_WIDTH, 26, width of the PC and memory address.
DATA_WIDTH, 32, instruction word width; fixed at 4 bytes.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
inicio  input  1  one-cycle pulse that starts a load; sampled only in OCIOSO, CONCLUIDO or ERRO.
num_palavras  input  ADDR_WIDTH  number of words to load; sampled on the accepted inicio.
byte_in  input  8  incoming program byte, MSB-first within each word.
byte_valid  input  1  byte_in is valid.
byte_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  instruction-memory write enable, one cycle per word.
mem_endereco  output  ADDR_WIDTH  write address.
mem_dado  output  DATA_WIDTH  write data.
cpu_hold  output  1  stalls the CPU and forces PC to 0 while high.
concluido  output  1  load finished successfully.
erro  output  1  load rejected.
palavras_escritas  output  ADDR_WIDTH  count of words written in the current load.

Behaviour:
- Reset (asynchronous, active-low):
  - State OCIOSO.
  - byte_ready=0, mem_we=0, mem_endereco=0, mem_dado=0.
  - cpu_hold=1, concluido=0, erro=0, palavras_escritas=0, byte counter=0.
- All outputs are registered.
- A byte transfer occurs on any rising edge where byte_valid=1 and byte_ready=1.
- byte_ready=1 only in state RECEBE.
- States and transitions:
  - OCIOSO: on inicio, if num_palavras==0 or num_palavras>MEM_SIZE, go to ERRO; otherwise clear the counters, latch num_palavras and go to RECEBE. cpu_hold stays 1.
  - RECEBE: each transfer shifts the byte into the assembly register (word = {word[23:0], byte_in}) and increments the byte counter mod 4. On the 4th byte, go to ESCREVE.
  - ESCREVE: exactly one cycle. mem_we=1, mem_endereco=palavras_escritas, mem_dado=assembled word. palavras_escritas increments at the end of the cycle. If the new count equals the latched num_palavras, go to CONCLUIDO; otherwise return to RECEBE.
  - CONCLUIDO: concluido=1, cpu_hold=0. On inicio, re-validate exactly as in OCIOSO; a valid inicio clears concluido and sets cpu_hold=1.
  - ERRO: erro=1 (sticky), cpu_hold=1. On inicio, re-validate exactly as in OCIOSO; erro clears only on a valid start.
- Latency:
  - 4th byte accepted at edge k; mem_we is high in the cycle after edge k; byte_ready returns at edge k+2.
  - Sustained throughput: 1 word per 5 cycles with byte_valid held high.
- Boundary conditions:
  - inicio in RECEBE or ESCREVE is ignored.
  - byte_valid outside RECEBE is ignored; no byte is consumed.
  - num_palavras==MEM_SIZE is valid; the last write address is MEM_SIZE-1 and addresses never wrap.
  - A partial word at stream end leaves the loader in RECEBE indefinitely with cpu_hold=1; there is no timeout.
  - Reset mid-load returns to OCIOSO. Memory contents already written are left unchanged.

Decomposition:
- Package carregador_pkg holds:
  - State encoding: OCIOSO=0, RECEBE=1, ESCREVE=2, CONCLUIDO=3, ERRO=4 (3-bit).
  - BYTES_POR_PALAVRA=4.
  - Default MEM_SIZE and ADDR_WIDTH constants.
- One sub-module, montador_de_palavra: 4-byte shift register plus 2-bit byte counter, with ports clock, reset, shift, clear, byte_in, palavra, palavra_pronta. The FSM and address counter stay in carregador_de_programa.

Test Plan:
- Reset asserted mid-stream after 2 of 4 bytes -> all outputs at reset values immediately; cpu_hold=1; no mem_we pulse; a later valid load starts at address 0.
- inicio with num_palavras=2; bytes 74,00,00,2D, 08,63,00,06 streamed with valid held high -> mem_we pulses at addr 0 data 0x7400002D, then addr 1 data 0x08630006; 5-cycle spacing; concluido=1 and cpu_hold=0 one cycle after the 2nd write.
- inicio with num_palavras=0, then with num_palavras=151 -> ERRO, erro=1, cpu_hold=1, no write, byte_ready stays 0; then inicio with num_palavras=1 -> erro clears.
- byte_valid toggled 1,0,0,1,1,0,1 with num_palavras=1 -> exactly 4 bytes accepted; one write, at addr 0.
- num_palavras=150 with random data -> 150 writes at addresses 0..149 in order; palavras_escritas=150; no address past 149.
- inicio pulsed during RECEBE -> ignored; the load completes with the original count.

Source files
------------

// File: rtl/carregador_pkg.sv
// carregador_pkg
// Shared constants for the boot-time program loader: FSM state encoding,
// bytes per instruction word and default memory geometry.
package carregador_pkg;

  localparam logic [2:0] OCIOSO    = 3'd0;
  localparam logic [2:0] RECEBE    = 3'd1;
  localparam logic [2:0] ESCREVE   = 3'd2;
  localparam logic [2:0] CONCLUIDO = 3'd3;
  localparam logic [2:0] ERRO      = 3'd4;

  localparam int BYTES_POR_PALAVRA = 4;
  localparam int MEM_SIZE_PADRAO   = 150;
  localparam int ADDR_WIDTH_PADRAO = 26;

endpackage

// File: rtl/montador_de_palavra.sv
// montador_de_palavra
// Assembles BYTES_POR_PALAVRA bytes, MSB first, into one instruction word.
// Ports:
//   clock, reset   - system clock, asynchronous active-low reset
//   shift          - a byte is being accepted this cycle
//   clear          - discard any partial word and restart the byte count
//   byte_in        - incoming byte
//   palavra        - assembly register (holds the complete word once full)
//   palavra_pronta - high in the cycle whose shift completes a word
module montador_de_palavra
  import carregador_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           shift,
  input  logic                           clear,
  input  logic [7:0]                     byte_in,
  output logic [8*BYTES_POR_PALAVRA-1:0] palavra,
  output logic                           palavra_pronta
);

  localparam int CW = $clog2(BYTES_POR_PALAVRA);

  logic [CW-1:0] contador;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      palavra  <= '0;
      contador <= '0;
    end else if (clear) begin
      palavra  <= '0;
      contador <= '0;
    end else if (shift) begin
      palavra  <= {palavra[8*BYTES_POR_PALAVRA-9:0], byte_in};
      contador <= contador + CW'(1);
    end
  end

  // Combinational so the FSM can leave RECEBE on the same edge the last byte lands.
  assign palavra_pronta = shift && (contador == CW'(BYTES_POR_PALAVRA - 1));

endmodule

// File: rtl/carregador_de_programa.sv
// carregador_de_programa
// Boot-time instruction-memory loader. Receives a byte stream over a
// valid/ready handshake, builds big-endian 32-bit words and writes them at
// consecutive addresses from 0. Keeps the CPU stalled until the load is done.
// Ports:
//   clock, reset        - system clock, asynchronous active-low reset
//   inicio              - start pulse (honoured in OCIOSO, CONCLUIDO, ERRO)
//   num_palavras        - words to load, sampled with inicio
//   byte_in/byte_valid  - byte stream input, byte_ready is the accept
//   mem_we/mem_endereco/mem_dado - instruction memory write port
//   cpu_hold            - CPU stall / PC forced to 0 while high
//   concluido, erro     - load finished / load rejected
//   palavras_escritas   - words written in the current load
module carregador_de_programa
  import carregador_pkg::*;
#(
  parameter int MEM_SIZE   = MEM_SIZE_PADRAO,
  parameter int ADDR_WIDTH = ADDR_WIDTH_PADRAO,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic [ADDR_WIDTH-1:0] num_palavras,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_endereco,
  output logic [DATA_WIDTH-1:0] mem_dado,
  output logic                  cpu_hold,
  output logic                  concluido,
  output logic                  erro,
  output logic [ADDR_WIDTH-1:0] palavras_escritas
);

  logic [2:0]            estado;
  logic [ADDR_WIDTH-1:0] total;
  logic                  aguardando;
  logic                  num_valido;
  logic                  partida;
  logic                  transferencia;
  logic                  palavra_pronta;
  logic [ADDR_WIDTH-1:0] proxima_contagem;

  assign aguardando       = (estado == OCIOSO) || (estado == CONCLUIDO) || (estado == ERRO);
  assign num_valido       = (num_palavras != '0) && (num_palavras <= ADDR_WIDTH'(MEM_SIZE));
  assign partida          = inicio && aguardando && num_valido;
  assign transferencia    = byte_valid && byte_ready;
  assign proxima_contagem = palavras_escritas + ADDR_WIDTH'(1);

  // mem_dado comes straight from the assembly register: it is stable and
  // complete throughout the ESCREVE cycle because no byte is accepted there.
  montador_de_palavra u_montador (
    .clock          (clock),
    .reset          (reset),
    .shift          (transferencia),
    .clear          (partida),
    .byte_in        (byte_in),
    .palavra        (mem_dado),
    .palavra_pronta (palavra_pronta)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado            <= OCIOSO;
      total             <= '0;
      byte_ready        <= 1'b0;
      mem_we            <= 1'b0;
      mem_endereco      <= '0;
      cpu_hold          <= 1'b1;
      concluido         <= 1'b0;
      erro              <= 1'b0;
      palavras_escritas <= '0;
    end else begin
      mem_we <= 1'b0;
      case (estado)
        OCIOSO, CONCLUIDO, ERRO: begin
          if (inicio) begin
            cpu_hold  <= 1'b1;
            concluido <= 1'b0;
            if (num_valido) begin
              estado            <= RECEBE;
              total             <= num_palavras;
              palavras_escritas <= '0;
              byte_ready        <= 1'b1;
              erro              <= 1'b0;
            end else begin
              estado <= ERRO;
              erro   <= 1'b1;
            end
          end
        end
        RECEBE: begin
          if (palavra_pronta) begin
            estado       <= ESCREVE;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b1;
            mem_endereco <= palavras_escritas;
          end
        end
        ESCREVE: begin
          palavras_escritas <= proxima_contagem;
          if (proxima_contagem == total) begin
            estado    <= CONCLUIDO;
            concluido <= 1'b1;
            cpu_hold  <= 1'b0;
          end else begin
            estado     <= RECEBE;
            byte_ready <= 1'b1;
          end
        end
        default: begin
          estado     <= OCIOSO;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_de_programa.sv
// tb_carregador_de_programa
// Directed bench for the program loader: reset values, normal loads,
// rejected starts, handshake gaps, ignored inicio, mid-load reset and a
// full-memory load.
module tb_carregador_de_programa;

  localparam int AW = 26;

  logic          clock = 1'b0;
  logic          reset;
  logic          inicio;
  logic [AW-1:0] num_palavras;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_endereco;
  logic [31:0]   mem_dado;
  logic          cpu_hold;
  logic          concluido;
  logic          erro;
  logic [AW-1:0] palavras_escritas;

  carregador_de_programa dut (
    .clock             (clock),
    .reset             (reset),
    .inicio            (inicio),
    .num_palavras      (num_palavras),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .mem_we            (mem_we),
    .mem_endereco      (mem_endereco),
    .mem_dado          (mem_dado),
    .cpu_hold          (cpu_hold),
    .concluido         (concluido),
    .erro              (erro),
    .palavras_escritas (palavras_escritas)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   dado;
    int            ciclo;
  } escrita_t;

  escrita_t   wr_q[$];
  logic [7:0] fila[$];
  logic [31:0] esp_q[$];
  int ciclo = 0;
  int n_total = 0;
  int n_ok = 0;

  always @(posedge clock) begin
    #1;
    ciclo++;
    if (mem_we) wr_q.push_back('{mem_endereco, mem_dado, ciclo});
  end

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_total++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
  endtask

  task automatic inicia(input int n);
    @(negedge clock);
    inicio = 1'b1;
    num_palavras = AW'(n);
    @(negedge clock);
    inicio = 1'b0;
  endtask

  // Pushes bytes onto fila and the matching big-endian words onto esp_q.
  task automatic adiciona_palavra(input logic [31:0] w);
    fila.push_back(w[31:24]);
    fila.push_back(w[23:16]);
    fila.push_back(w[15:8]);
    fila.push_back(w[7:0]);
    esp_q.push_back(w);
  endtask

  task automatic envia(input string tag, input int budget);
    int idx = 0;
    int c = 0;
    while (idx < fila.size() && c < budget) begin
      @(negedge clock);
      byte_in = fila[idx];
      byte_valid = 1'b1;
      if (byte_ready) idx++;
      c++;
    end
    @(negedge clock);
    byte_valid = 1'b0;
    verifica(tag, idx, fila.size());
    fila.delete();
  endtask

  task automatic espera_escritas(input string tag, input int n, input int budget);
    int c = 0;
    while (wr_q.size() < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    verifica(tag, wr_q.size(), n);
  endtask

  task automatic confere_escritas(input string tag);
    for (int i = 0; i < esp_q.size() && i < wr_q.size(); i++) begin
      verifica($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, i);
      verifica($sformatf("%s_dado%0d", tag, i), wr_q[i].dado, esp_q[i]);
    end
  endtask

  initial begin
    logic [6:0] padrao;
    int idx;
    int max_addr;

    reset = 1'b0;
    inicio = 1'b0;
    num_palavras = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clock);

    verifica("rst_byte_ready", byte_ready, 0);
    verifica("rst_mem_we", mem_we, 0);
    verifica("rst_endereco", mem_endereco, 0);
    verifica("rst_dado", mem_dado, 0);
    verifica("rst_cpu_hold", cpu_hold, 1);
    verifica("rst_concluido", concluido, 0);
    verifica("rst_erro", erro, 0);
    verifica("rst_palavras", palavras_escritas, 0);
    reset = 1'b1;
    @(negedge clock);
    verifica("ocioso_hold", cpu_hold, 1);

    // Two-word load with byte_valid held high.
    wr_q.delete(); esp_q.delete();
    inicia(2);
    verifica("start_ready", byte_ready, 1);
    adiciona_palavra(32'h7400002D);
    adiciona_palavra(32'h08630006);
    envia("dois_envio", 40);
    espera_escritas("dois_escritas", 2, 10);
    confere_escritas("dois");
    if (wr_q.size() == 2) verifica("dois_espaco", wr_q[1].ciclo - wr_q[0].ciclo, 5);
    verifica("dois_hold_ultimo", cpu_hold, 1);
    @(negedge clock);
    verifica("dois_concluido", concluido, 1);
    verifica("dois_hold", cpu_hold, 0);
    verifica("dois_palavras", palavras_escritas, 2);

    // Rejected starts: zero words, then one more than the memory holds.
    wr_q.delete(); esp_q.delete();
    inicia(0);
    verifica("zero_erro", erro, 1);
    verifica("zero_hold", cpu_hold, 1);
    verifica("zero_concluido", concluido, 0);
    byte_valid = 1'b1;
    repeat (3) @(negedge clock);
    verifica("zero_ready", byte_ready, 0);
    byte_valid = 1'b0;
    inicia(151);
    verifica("excesso_erro", erro, 1);
    verifica("excesso_ready", byte_ready, 0);
    verifica("erro_sem_escrita", wr_q.size(), 0);

    // Valid start clears erro; byte_valid gaps 1,0,0,1,1,0,1.
    inicia(1);
    verifica("valido_erro", erro, 0);
    verifica("valido_ready", byte_ready, 1);
    adiciona_palavra(32'h11223344);
    padrao = 7'b1011001;
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      byte_valid = padrao[i];
      byte_in = (idx < 4) ? fila[idx] : 8'hEE;
      if (byte_valid && byte_ready) idx++;
      @(negedge clock);
    end
    byte_valid = 1'b1;
    byte_in = 8'hEE;
    repeat (5) @(negedge clock);
    byte_valid = 1'b0;
    fila.delete();
    verifica("gaps_aceitos", idx, 4);
    verifica("gaps_escritas", wr_q.size(), 1);
    confere_escritas("gaps");
    verifica("gaps_palavras", palavras_escritas, 1);
    verifica("gaps_concluido", concluido, 1);

    // inicio during RECEBE must be ignored.
    wr_q.delete(); esp_q.delete();
    inicia(2);
    adiciona_palavra(32'hA1B2C3D4);
    adiciona_palavra(32'h55667788);
    for (int i = 0; i < 6; i++) void'(fila.pop_back());
    envia("parcial_envio", 10);
    repeat (4) @(negedge clock);
    verifica("parcial_hold", cpu_hold, 1);
    verifica("parcial_sem_escrita", wr_q.size(), 0);
    inicio = 1'b1;
    num_palavras = AW'(1);
    @(negedge clock);
    inicio = 1'b0;
    verifica("ignora_ready", byte_ready, 1);
    fila.push_back(8'hC3); fila.push_back(8'hD4);
    fila.push_back(8'h55); fila.push_back(8'h66);
    fila.push_back(8'h77); fila.push_back(8'h88);
    envia("ignora_envio", 40);
    espera_escritas("ignora_escritas", 2, 10);
    confere_escritas("ignora");
    @(negedge clock);
    verifica("ignora_palavras", palavras_escritas, 2);
    verifica("ignora_concluido", concluido, 1);

    // Reset after 2 of 4 bytes.
    wr_q.delete(); esp_q.delete();
    inicia(1);
    fila.push_back(8'hAA); fila.push_back(8'hBB);
    envia("meio_envio", 10);
    #2 reset = 1'b0;
    #1;
    verifica("meio_ready", byte_ready, 0);
    verifica("meio_dado", mem_dado, 0);
    verifica("meio_hold", cpu_hold, 1);
    verifica("meio_concluido", concluido, 0);
    @(negedge clock);
    reset = 1'b1;
    verifica("meio_sem_escrita", wr_q.size(), 0);
    inicia(1);
    adiciona_palavra(32'hCAFEF00D);
    envia("pos_reset_envio", 20);
    espera_escritas("pos_reset_escritas", 1, 10);
    confere_escritas("pos_reset");

    // Full memory: 150 words of random data.
    wr_q.delete(); esp_q.delete();
    inicia(150);
    for (int i = 0; i < 150; i++) adiciona_palavra($urandom);
    envia("cheia_envio", 1000);
    espera_escritas("cheia_escritas", 150, 10);
    confere_escritas("cheia");
    @(negedge clock);
    repeat (3) @(negedge clock);
    max_addr = 0;
    foreach (wr_q[i]) if (int'(wr_q[i].addr) > max_addr) max_addr = int'(wr_q[i].addr);
    verifica("cheia_max_addr", max_addr, 149);
    verifica("cheia_total", wr_q.size(), 150);
    verifica("cheia_palavras", palavras_escritas, 150);
    verifica("cheia_concluido", concluido, 1);
    verifica("cheia_hold", cpu_hold, 0);

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
